// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: synchronous instruction-memory port plus the
// valid/ready instruction channel towards decode.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_en;
    logic [31:0]        imem_data;
    logic               inst_vld;
    logic               inst_rdy;
    logic [31:0]        inst;
    logic [ADDR_W-1:0]  inst_pc;

    modport master (
        output imem_addr, imem_en, inst_vld, inst, inst_pc,
        input  imem_data, inst_rdy
    );

    modport slave (
        input  imem_addr, imem_en, inst_vld, inst, inst_pc,
        output imem_data, inst_rdy
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, 1-cycle imem access, output register plus
// 1-entry skid buffer, redirect/interrupt squashing with EPC capture, debug stepping.
module fetch_unit #(
    parameter int          ADDR_W    = 32,
    parameter int          IMEM_AW   = 6,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC   = 32'h0000_0040
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic              int_en,
    input  logic              interrupter,
    input  logic              redirect_vld,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_unit_if.master      bus,
    output logic              int_taken,
    output logic [ADDR_W-1:0] epc
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] INT_PC   = ADDR_W'(INT_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_vld_q, fetch_vld_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              out_vld_q, out_vld_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              skid_vld_q, skid_vld_d;
    logic [31:0]       skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              int_pending_q, int_pending_d;
    logic              credit_q, credit_d;
    logic [2:0]        int_sync_q, int_sync_d;
    logic [2:0]        step_sync_q, step_sync_d;
    logic              int_taken_q, int_taken_d;
    logic [ADDR_W-1:0] epc_q, epc_d;

    logic take_int_s, flush_s, credit_ok_s, imem_en_s, out_free_s;
    logic int_edge_s, step_edge_s;

    // Next-state logic for PC, fetch tag, output/skid buffers, interrupt and step control
    always_comb begin
        // sync bits: [0] first stage, [1] second stage, [2] previous value for edge detect
        int_sync_d  = {int_sync_q[1:0], interrupter};
        step_sync_d = {step_sync_q[1:0], debug_step};
        int_edge_s  = int_sync_q[1] & ~int_sync_q[2];
        step_edge_s = step_sync_q[1] & ~step_sync_q[2];

        take_int_s = int_pending_q & int_en & ~redirect_vld;
        flush_s    = redirect_vld | take_int_s;
        if (debug_en) begin
            credit_ok_s = credit_q;
        end else begin
            credit_ok_s = 1'b1;
        end
        imem_en_s  = ~flush_s & credit_ok_s & ~skid_vld_q & ~(out_vld_q & ~bus.inst_rdy);
        out_free_s = ~out_vld_q | bus.inst_rdy;

        pc_d        = pc_q;
        fetch_vld_d = imem_en_s;
        fetch_pc_d  = fetch_pc_q;
        out_vld_d   = out_vld_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        epc_d       = epc_q;
        int_taken_d = take_int_s;

        if (redirect_vld) begin
            pc_d = redirect_pc;
        end else if (take_int_s) begin
            pc_d = INT_PC;
        end else if (imem_en_s) begin
            pc_d = pc_q + ADDR_W'(32'd4);
        end else begin
            pc_d = pc_q;
        end

        if (imem_en_s) begin
            fetch_pc_d = pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // The response of the previous cycle's fetch is dropped on a flush
        if (flush_s) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free_s) begin
            if (skid_vld_q) begin
                out_vld_d   = 1'b1;
                out_inst_d  = skid_inst_q;
                out_pc_d    = skid_pc_q;
                skid_vld_d  = fetch_vld_q;
                skid_inst_d = bus.imem_data;
                skid_pc_d   = fetch_pc_q;
            end else if (fetch_vld_q) begin
                out_vld_d  = 1'b1;
                out_inst_d = bus.imem_data;
                out_pc_d   = fetch_pc_q;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (fetch_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_inst_d = bus.imem_data;
            skid_pc_d   = fetch_pc_q;
        end else begin
            skid_vld_d = skid_vld_q;
        end

        // EPC is the oldest instruction decode has not yet taken
        if (take_int_s) begin
            if (out_vld_q && !bus.inst_rdy) begin
                epc_d = out_pc_q;
            end else if (skid_vld_q) begin
                epc_d = skid_pc_q;
            end else if (fetch_vld_q) begin
                epc_d = fetch_pc_q;
            end else begin
                epc_d = pc_q;
            end
        end else begin
            epc_d = epc_q;
        end

        if (take_int_s) begin
            int_pending_d = 1'b0;
        end else begin
            int_pending_d = int_pending_q | int_edge_s;
        end

        credit_d = step_edge_s | (credit_q & ~imem_en_s);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            fetch_vld_q   <= 1'b0;
            fetch_pc_q    <= '0;
            out_vld_q     <= 1'b0;
            out_inst_q    <= 32'h0000_0000;
            out_pc_q      <= '0;
            skid_vld_q    <= 1'b0;
            skid_inst_q   <= 32'h0000_0000;
            skid_pc_q     <= '0;
            int_pending_q <= 1'b0;
            credit_q      <= 1'b0;
            int_sync_q    <= 3'b000;
            step_sync_q   <= 3'b000;
            int_taken_q   <= 1'b0;
            epc_q         <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_vld_q   <= fetch_vld_d;
            fetch_pc_q    <= fetch_pc_d;
            out_vld_q     <= out_vld_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            skid_vld_q    <= skid_vld_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            int_pending_q <= int_pending_d;
            credit_q      <= credit_d;
            int_sync_q    <= int_sync_d;
            step_sync_q   <= step_sync_d;
            int_taken_q   <= int_taken_d;
            epc_q         <= epc_d;
        end
    end

    assign bus.imem_en   = imem_en_s;
    assign bus.imem_addr = pc_q[IMEM_AW+1:2];
    assign bus.inst_vld  = out_vld_q;
    assign bus.inst      = out_inst_q;
    assign bus.inst_pc   = out_pc_q;
    assign int_taken     = int_taken_q;
    assign epc           = epc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural 1-cycle instruction memory whose word
// at byte address A reads 32'hC0DE_0000 | A (A within the 256-byte memory).
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        debug_en;
    logic        debug_step;
    logic        int_en;
    logic        interrupter;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        int_taken;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.ADDR_W(32), .IMEM_AW(6)) bus ();

    fetch_unit #(
        .ADDR_W(32), .IMEM_AW(6), .RESET_VEC(32'h0000_0000), .INT_VEC(32'h0000_0040)
    ) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .int_en(int_en), .interrupter(interrupter), .redirect_vld(redirect_vld),
        .redirect_pc(redirect_pc), .bus(bus), .int_taken(int_taken), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_data <= 32'hC0DE_0000 | {24'h000000, bus.imem_addr, 2'b00};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          n;
        int          hs;
        int          fetches;
        logic [31:0] hs_pc;

        rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0; int_en = 1'b1;
        interrupter = 1'b0; redirect_vld = 1'b0; redirect_pc = 32'h0000_0000;
        bus.inst_rdy = 1'b1;

        repeat (2) tick();
        check("rst_vld", bus.inst_vld, 64'd0);
        check("rst_inst", bus.inst, 64'd0);
        check("rst_pc", bus.inst_pc, 64'd0);
        check("rst_int_taken", int_taken, 64'd0);
        check("rst_epc", epc, 64'd0);

        // cycle 0 after release
        rst = 1'b1;
        #1;
        check("c0_imem_en", bus.imem_en, 64'd1);
        check("c0_imem_addr", bus.imem_addr, 64'd0);
        tick();
        check("c1_vld", bus.inst_vld, 64'd0);
        check("c1_imem_addr", bus.imem_addr, 64'd1);
        tick();
        check("c2_vld", bus.inst_vld, 64'd1);
        check("c2_pc", bus.inst_pc, 64'h0);
        check("c2_inst", bus.inst, 64'hC0DE_0000);
        tick();
        check("c3_pc", bus.inst_pc, 64'h4);
        tick();
        check("c4_pc", bus.inst_pc, 64'h8);

        // stall decode for cycles 4..6
        bus.inst_rdy = 1'b0;
        #1;
        check("stall0_imem_en", bus.imem_en, 64'd0);
        tick();
        check("stall1_pc", bus.inst_pc, 64'h8);
        check("stall1_imem_en", bus.imem_en, 64'd0);
        tick();
        check("stall2_pc", bus.inst_pc, 64'h8);
        check("stall2_vld", bus.inst_vld, 64'd1);
        check("stall2_imem_en", bus.imem_en, 64'd0);
        tick();
        bus.inst_rdy = 1'b1;
        check("rel_pc8", bus.inst_pc, 64'h8);
        tick();
        check("rel_pc12_vld", bus.inst_vld, 64'd1);
        check("rel_pc12", bus.inst_pc, 64'hC);
        check("rel_inst12", bus.inst, 64'hC0DE_000C);
        tick();
        check("rel_bubble", bus.inst_vld, 64'd0);

        // 0x10 is in flight now; redirect to 0x100
        redirect_vld = 1'b1; redirect_pc = 32'h0000_0100;
        #1;
        check("redir_no_fetch", bus.imem_en, 64'd0);
        tick();
        redirect_vld = 1'b0;
        #1;
        check("redir_t1_vld", bus.inst_vld, 64'd0);
        check("redir_t1_imem_en", bus.imem_en, 64'd1);
        check("redir_t1_addr", bus.imem_addr, 64'd0);
        tick();
        check("redir_t2_vld", bus.inst_vld, 64'd0);
        tick();
        check("redir_t3_vld", bus.inst_vld, 64'd1);
        check("redir_t3_pc", bus.inst_pc, 64'h100);
        tick();
        check("redir_t4_pc", bus.inst_pc, 64'h104);

        // move to 0x20, then hold it unaccepted while the interrupt arrives
        redirect_vld = 1'b1; redirect_pc = 32'h0000_0020;
        tick();
        redirect_vld = 1'b0;
        check("redir2_squash", bus.inst_vld, 64'd0);
        tick();
        tick();
        check("hold_pc20", bus.inst_pc, 64'h20);
        check("hold_inst20", bus.inst, 64'hC0DE_0020);
        bus.inst_rdy = 1'b0;
        interrupter = 1'b1;
        n = 0;
        while (int_taken !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check("int_taken_seen", int_taken, 64'd1);
        check("int_epc", epc, 64'h20);
        check("int_squash_vld", bus.inst_vld, 64'd0);
        bus.inst_rdy = 1'b1;
        interrupter = 1'b0;
        #1;
        check("int_fetch_en", bus.imem_en, 64'd1);
        check("int_fetch_addr", bus.imem_addr, 64'h10);
        tick();
        check("int_pulse_end", int_taken, 64'd0);
        tick();
        check("int_vec_vld", bus.inst_vld, 64'd1);
        check("int_vec_pc", bus.inst_pc, 64'h40);
        check("int_vec_inst", bus.inst, 64'hC0DE_0040);

        // request held pending while int_en is low
        int_en = 1'b0;
        repeat (4) tick();
        interrupter = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("masked_no_take", int_taken, 64'd0);
        end
        int_en = 1'b1;
        redirect_vld = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        check("both_no_fetch", bus.imem_en, 64'd0);
        tick();
        redirect_vld = 1'b0;
        #1;
        check("both_t1_not_taken", int_taken, 64'd0);
        check("both_t1_no_fetch", bus.imem_en, 64'd0);
        tick();
        check("both_t2_taken", int_taken, 64'd1);
        check("both_t2_epc", epc, 64'h200);
        tick();
        check("both_t3_vld", bus.inst_vld, 64'd0);
        tick();
        check("both_t4_pc", bus.inst_pc, 64'h40);
        interrupter = 1'b0;

        // asynchronous reset mid-stream, then come up in single-step mode
        debug_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_vld", bus.inst_vld, 64'd0);
        check("arst_pc", bus.inst_pc, 64'd0);
        check("arst_epc", epc, 64'd0);
        tick();
        rst = 1'b1;
        hs = 0;
        fetches = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.imem_en) fetches++;
            tick();
            if (bus.inst_vld && bus.inst_rdy) hs++;
        end
        check("dbg_idle_hs", hs, 64'd0);
        check("dbg_idle_fetch", fetches, 64'd0);

        for (int k = 0; k < 3; k++) begin
            debug_step = 1'b1;
            hs = 0;
            hs_pc = 32'hFFFF_FFFF;
            for (int i = 0; i < 14; i++) begin
                tick();
                if (i == 2) debug_step = 1'b0;
                if (bus.inst_vld && bus.inst_rdy) begin
                    hs++;
                    hs_pc = bus.inst_pc;
                end
            end
            check("dbg_step_hs", hs, 64'd1);
            check("dbg_step_pc", hs_pc, 64'(k * 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
